// File: rtl/dmx_pkg.sv
// Shared types and constants for the DMX512 receive path.
package dmx_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_BREAK,
    ST_MARK,
    ST_START,
    ST_DATA,
    ST_STOP
  } dmx_state_t;

  localparam logic [7:0]  DMX_START_CODE       = 8'h00;
  localparam int unsigned DEFAULT_BIT_CLOCKS   = 192;
  localparam int unsigned DEFAULT_BREAK_CLOCKS = 4224;
  localparam int unsigned SLOT_COUNT_W         = 10;

endpackage

// File: rtl/dmx_byte_rx.sv
// DMX512 line receiver: synchronizer, break detector and start/data/stop bit timing.
// Sample strobes are combinational so the frame writer can register them in the same cycle.
module dmx_byte_rx
  import dmx_pkg::*;
#(
  parameter int unsigned BIT_CLOCKS   = DEFAULT_BIT_CLOCKS,
  parameter int unsigned BREAK_CLOCKS = DEFAULT_BREAK_CLOCKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       dmx_in,
  output logic       byte_valid_c,
  output logic [7:0] byte_c,
  output logic       framing_error_c,
  output logic       break_detected_c
);

  localparam int unsigned LOW_W = $clog2(BREAK_CLOCKS + 1);
  localparam int unsigned BIT_W = $clog2(BIT_CLOCKS + 1);

  localparam logic [LOW_W-1:0] LOW_MAX       = LOW_W'(BREAK_CLOCKS);
  localparam logic [LOW_W-1:0] LOW_BREAK_M1  = LOW_W'(BREAK_CLOCKS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST      = BIT_W'(BIT_CLOCKS - 1);
  localparam logic [BIT_W-1:0] HALF_LAST     = BIT_W'(BIT_CLOCKS / 2 - 1);

  logic [1:0]       r_sync;
  logic [LOW_W-1:0] r_low_cnt;
  dmx_state_t       r_state;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;

  logic w_rx;
  logic w_stop_sample;

  assign w_rx = r_sync[1];

  // Line idles high, so the synchronizer resets to the mark level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], dmx_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low_cnt <= '0;
    end else if (w_rx) begin
      r_low_cnt <= '0;
    end else if (r_low_cnt != LOW_MAX) begin
      r_low_cnt <= r_low_cnt + LOW_W'(1);
    end
  end

  assign break_detected_c = enable && !w_rx && (r_low_cnt == LOW_BREAK_M1);
  assign w_stop_sample    = enable && (r_state == ST_STOP) && (r_bit_cnt == BIT_LAST);
  assign byte_valid_c     = w_stop_sample && w_rx;
  assign framing_error_c  = w_stop_sample && !w_rx;
  assign byte_c           = r_shift;

  // Bit-timing FSM; a break overrides whatever the stop sample decided this cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_HUNT;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else if (!enable) begin
      r_state   <= ST_HUNT;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      case (r_state)
        ST_HUNT: begin
          r_bit_cnt <= '0;
        end
        ST_BREAK: begin
          if (w_rx) begin
            r_state <= ST_MARK;
          end
        end
        ST_MARK: begin
          if (!w_rx) begin
            r_state   <= ST_START;
            r_bit_cnt <= '0;
          end
        end
        ST_START: begin
          if (r_bit_cnt == HALF_LAST) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx ? ST_MARK : ST_DATA;
          end
        end
        ST_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            r_shift   <= {w_rx, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 3'd1;
            if (r_bit_idx == 3'd7) begin
              r_state <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            r_state   <= w_rx ? ST_MARK : ST_HUNT;
          end
        end
        default: begin
          r_state <= ST_HUNT;
        end
      endcase
      if (break_detected_c) begin
        r_state <= ST_BREAK;
      end
    end
  end

endmodule

// File: rtl/dmx_frame_writer.sv
// Packs received DMX512 slots two per word and writes them to pixel SRAM,
// flushing a half-filled word and reporting the slot count when a frame ends.
module dmx_frame_writer
  import dmx_pkg::*;
#(
  parameter int unsigned ADDRESS_BUS_WIDTH = 16,
  parameter int unsigned DATA_BUS_WIDTH    = 16,
  parameter int unsigned BASE_ADDRESS      = 32'h0000_E000,
  parameter int unsigned BIT_CLOCKS        = DEFAULT_BIT_CLOCKS,
  parameter int unsigned BREAK_CLOCKS      = DEFAULT_BREAK_CLOCKS,
  parameter int unsigned MAX_SLOTS         = 512
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dmx_in,
  input  logic                         enable,
  output logic [ADDRESS_BUS_WIDTH-1:0] write_address,
  output logic [DATA_BUS_WIDTH-1:0]    write_data,
  output logic                         write_strobe,
  output logic                         frame_done,
  output logic [SLOT_COUNT_W-1:0]      slot_count,
  output logic                         framing_error
);

  localparam int unsigned SLOT_W = $clog2(MAX_SLOTS + 1);

  localparam logic [SLOT_W-1:0]            SLOT_LIMIT = SLOT_W'(MAX_SLOTS);
  localparam logic [ADDRESS_BUS_WIDTH-1:0] BASE_ADDR  = ADDRESS_BUS_WIDTH'(BASE_ADDRESS);

  logic       w_byte_valid;
  logic [7:0] w_byte;
  logic       w_framing_error;
  logic       w_break;

  dmx_byte_rx #(
    .BIT_CLOCKS   (BIT_CLOCKS),
    .BREAK_CLOCKS (BREAK_CLOCKS)
  ) u_byte_rx (
    .clk              (clk),
    .rst_n            (rst_n),
    .enable           (enable),
    .dmx_in           (dmx_in),
    .byte_valid_c     (w_byte_valid),
    .byte_c           (w_byte),
    .framing_error_c  (w_framing_error),
    .break_detected_c (w_break)
  );

  // Frame state: armed once a break has been seen, accepted after a 0x00 start code.
  logic                    r_armed;
  logic                    r_sc_seen;
  logic                    r_accepted;
  logic                    r_hi_pending;
  logic [7:0]              r_hi_byte;
  logic [SLOT_W-1:0]       r_data_cnt;
  logic                    r_done_pending;
  logic [SLOT_COUNT_W-1:0] r_done_cnt;

  logic                         w_is_start_code;
  logic                         w_take_slot;
  logic [ADDRESS_BUS_WIDTH-1:0] w_word_addr;
  logic [SLOT_W-1:0]            w_final_cnt;
  logic                         w_flush_pending;
  logic [7:0]                   w_flush_hi;

  assign w_is_start_code = w_byte_valid && r_armed && !r_sc_seen;
  assign w_take_slot     = w_byte_valid && r_accepted && (r_data_cnt < SLOT_LIMIT);

  // Word for slot n (1-based) is (n-1)/2; before or after taking an odd slot that is r_data_cnt/2.
  assign w_word_addr     = BASE_ADDR + ADDRESS_BUS_WIDTH'(r_data_cnt >> 1);
  assign w_final_cnt     = r_data_cnt + SLOT_W'(w_take_slot);

  // A stop sample coinciding with a break is folded in before the flush decision.
  assign w_flush_pending = w_take_slot ? !r_data_cnt[0] : r_hi_pending;
  assign w_flush_hi      = w_take_slot ? w_byte : r_hi_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_address  <= '0;
      write_data     <= '0;
      write_strobe   <= 1'b0;
      frame_done     <= 1'b0;
      slot_count     <= '0;
      framing_error  <= 1'b0;
      r_armed        <= 1'b0;
      r_sc_seen      <= 1'b0;
      r_accepted     <= 1'b0;
      r_hi_pending   <= 1'b0;
      r_hi_byte      <= '0;
      r_data_cnt     <= '0;
      r_done_pending <= 1'b0;
      r_done_cnt     <= '0;
    end else begin
      write_strobe  <= 1'b0;
      frame_done    <= 1'b0;
      framing_error <= 1'b0;
      if (!enable) begin
        r_armed        <= 1'b0;
        r_sc_seen      <= 1'b0;
        r_accepted     <= 1'b0;
        r_hi_pending   <= 1'b0;
        r_data_cnt     <= '0;
        r_done_pending <= 1'b0;
      end else begin
        framing_error <= w_framing_error;

        if (r_done_pending) begin
          frame_done     <= 1'b1;
          slot_count     <= r_done_cnt;
          r_done_pending <= 1'b0;
        end

        if (w_is_start_code) begin
          r_sc_seen  <= 1'b1;
          r_accepted <= (w_byte == DMX_START_CODE);
        end

        if (w_take_slot) begin
          r_data_cnt <= w_final_cnt;
          if (!r_data_cnt[0]) begin
            r_hi_byte    <= w_byte;
            r_hi_pending <= 1'b1;
          end else begin
            write_strobe  <= 1'b1;
            write_address <= w_word_addr;
            write_data    <= DATA_BUS_WIDTH'({r_hi_byte, w_byte});
            r_hi_pending  <= 1'b0;
          end
        end

        // Break ends the frame: flush a lone high byte first, frame_done one cycle later.
        if (w_break) begin
          r_armed      <= 1'b1;
          r_sc_seen    <= 1'b0;
          r_accepted   <= 1'b0;
          r_hi_pending <= 1'b0;
          r_data_cnt   <= '0;
          if (r_accepted) begin
            if (w_flush_pending) begin
              write_strobe   <= 1'b1;
              write_address  <= w_word_addr;
              write_data     <= DATA_BUS_WIDTH'({w_flush_hi, 8'h00});
              r_done_pending <= 1'b1;
              r_done_cnt     <= SLOT_COUNT_W'(w_final_cnt);
            end else begin
              frame_done <= 1'b1;
              slot_count <= SLOT_COUNT_W'(w_final_cnt);
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/dmx_frame_writer.md
# dmx_frame_writer

Receives a DMX512 stream on the `DMX_IN` pin and writes the slot data into pixel SRAM through the same write port that `spi_in` drives (`write_address`/`write_data`/`write_strobe` into `sram_bus`). Incoming data is packed two slots per 16-bit word. This lets a lighting console fill the frame buffer that the LED output engines read. The block sits upstream of `sram_bus`, and its write port is arbitrated or muxed with `spi_in` at chip level.

## Interface
- `ADDRESS_BUS_WIDTH`, default 16: width of the word address.
- `DATA_BUS_WIDTH`, default 16: width of a write word; must be 16.
- `BASE_ADDRESS`, default 16'hE000: word address that receives slots 1 and 2.
- `BIT_CLOCKS`, default 192: clk cycles per DMX bit (48 MHz / 250 kbaud).
- `BREAK_CLOCKS`, default 4224: minimum continuous low time (88 µs) counted as a break.
- `MAX_SLOTS`, default 512: data slots accepted per frame; any further slots are dropped.
- `clk` (in, 1): 48 MHz HFOSC clock.
- `rst_n` (in, 1): reset. One clock; reset is asynchronous and active-low.
- `dmx_in` (in, 1): raw DMX line, asynchronous; idles high.
- `enable` (in, 1): when low, the block is held in HUNT and emits no writes.
- `write_address` (out, ADDRESS_BUS_WIDTH): word address; valid while `write_strobe` is high.
- `write_data` (out, 16): slot 2k+1 in [15:8], slot 2k+2 in [7:0].
- `write_strobe` (out, 1): one-cycle write pulse.
- `frame_done` (out, 1): one-cycle pulse when an accepted frame ends.
- `slot_count` (out, 10): number of data slots in the last accepted frame; updated together with `frame_done`.
- `framing_error` (out, 1): one-cycle pulse when a stop bit is sampled low.

## Operation
- `dmx_in` passes through a 2-FF synchronizer; all logic uses the synchronized value.
- A low-time counter counts consecutive low cycles and saturates at BREAK_CLOCKS.
  - Reaching BREAK_CLOCKS from any state except HUNT-while-disabled is a break.
  - On a break, any frame in progress ends (flush, see below) and the FSM goes to BREAK.
- FSM states:
  - HUNT: wait for a break.
  - BREAK: line low; go to MARK when the line goes high.
  - MARK: wait for a falling edge, then go to START.
  - START: wait BIT_CLOCKS/2 and sample. High means a glitch: return to MARK. Low goes to DATA.
  - DATA: sample 8 bits, LSB first, BIT_CLOCKS apart.
  - STOP: sample one BIT_CLOCKS later. High means the byte is valid; go to MARK and wait for the next start bit (the second stop bit and inter-slot MTBF are tolerated). Low pulses `framing_error`, drops the byte and goes to HUNT, unless the continuing low becomes a break.
- Slot 0 is the start code.
  - 0x00: the frame is accepted.
  - Any other value: the remaining slots are ignored until the next break. No writes, no `frame_done`.
- Packing:
  - An odd slot is latched as the high byte.
  - An even slot completes the word and issues a write at BASE_ADDRESS + (slot−1)/2.
- Slots beyond MAX_SLOTS are dropped. No address wrap.
- Flush: an accepted frame ends on a break.
  - If a high byte is pending, write it with the low byte 0x00.
  - Then pulse `frame_done` and load `slot_count`.
- Deasserting `enable` abandons the frame immediately (no flush, no `frame_done`) and forces HUNT.
- Reset values: all outputs 0, FSM in HUNT, low counter 0.

## Timing
- `write_strobe` is asserted in the cycle after the clk edge that samples the completing stop bit. Address and data are valid in that cycle and held until the next strobe.
- `sram_bus` applies no backpressure. The minimum strobe spacing is 22 bit times, so no buffering is needed.
- Flush order on a break: flush write in cycle N, then `frame_done` in cycle N+1. With no pending byte, `frame_done` is in cycle N.
- A break that coincides with a stop sample: the stop sample is taken first, then the break is processed in the same cycle (the byte counts if valid).
- Asynchronous reset mid-frame: outputs clear immediately, and no flush occurs after release.

## Structure
- Shared package `dmx_pkg`:
  - FSM state enum.
  - `DMX_START_CODE` = 8'h00.
  - Default BIT_CLOCKS and BREAK_CLOCKS.
- Sub-module `dmx_byte_rx`: synchronizer, low counter, and the START/DATA/STOP bit timing.
  - Outputs `byte_valid`, `byte`, `framing_error` and `break_detected`.
- The top level holds the slot counter, the start-code check, packing and flush.

## Test plan
- Break 100 µs, start code 0x00, slots 0x11, 0x22, 0x33, then a break → writes 0xE000 ← 0x1122, then 0xE001 ← 0x3300 after the second break; `frame_done` with `slot_count` = 3.
- Start code 0xCC followed by 10 slots → no `write_strobe` and no `frame_done`; the next 0x00 frame writes normally.
- 513 slots, all 0xA5 → 256 writes ending at 0xE0FF ← 0xA5A5; `slot_count` = 512; no write to 0xE100.
- Stop bit forced low in slot 4 (1 bit time) → `framing_error` pulse, no write for slot 4 onward, the block hunts and the next frame is received.
- Low pulse of BREAK_CLOCKS−1 cycles → not a break; the same pulse at exactly BREAK_CLOCKS → break recognised.
- `rst_n` pulsed low during slot 7, and `enable` dropped during slot 7 in a separate run → no flush write and no `frame_done`; reception resumes on the next break.
